// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Items shared by the pipeline stages: opcode values (ir[31:26]), the
//   MEM/WB stage state encoding, the default sequential PC increment, and
//   small opcode-classification helpers.
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b010000;
    localparam logic [5:0] OP_LW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    // MEM/WB stage states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Default sequential PC increment in bytes
    localparam int DEF_PC_STEP = 4;

    // Loads and stores are the only ops that visit the data memory
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Register-register ALU ops occupy the contiguous range ADD..SLT
    function automatic logic is_alu_op(input logic [5:0] op);
        return (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
//   Data-memory request engine for one LW/SW. A start pulse loads the
//   request fields; req/we/addr/wdata then stay stable until the memory acks
//   or TIMEOUT cycles pass without an ack. Read data is captured on the ack
//   cycle. A timeout raises the sticky err flag, cleared only by reset.
//
//   clk, rst_n          clock, synchronous active-low reset
//   i_start             load a new request (only while idle)
//   i_we/i_addr/i_wdata request fields captured on i_start
//   i_ack, i_rdata      memory handshake and load data
//   o_req/o_we/o_addr/o_wdata  memory port drive
//   o_done              last MEM cycle: ack seen or timeout expiring
//   o_timed_out         last request ended by timeout
//   o_rdata             load data captured at ack
//   o_err               sticky timeout flag
// ----------------------------------------------------------------------------
module dmem_if #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_req,
    output logic              o_we,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_done,
    output logic              o_timed_out,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_timed_out;
    logic              r_err;

    logic w_ack;
    logic w_expire;

    // An ack arriving in the cycle the count would reach TIMEOUT still
    // completes normally: expiry is only considered without an ack.
    assign w_ack    = r_req & i_ack;
    assign w_expire = r_req & ~i_ack & (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
        end else if (i_start) begin
            r_req       <= 1'b1;
            r_we        <= i_we;
            r_addr      <= i_addr;
            r_wdata     <= i_wdata;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else if (r_req) begin
            if (w_ack) begin
                r_req   <= 1'b0;
                r_rdata <= i_rdata;
            end else if (w_expire) begin
                r_req       <= 1'b0;
                r_timed_out <= 1'b1;
                r_err       <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_req       = r_req;
    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_done      = w_ack | w_expire;
    assign o_timed_out = r_timed_out;
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;

endmodule

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access / write-back stage. Accepts one executed instruction per
//   handshake, performs LW/SW through dmem_if, then spends exactly one WB
//   cycle presenting the register write-back and the next PC.
//
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               upstream handshake (ready only in IDLE)
//   op_i, alu_i, addr_i, ife_i, pc_i  executed instruction fields
//   dmem_req/we/addr/wdata/ack/rdata  data-memory port
//   reg_update, reg_o               one-cycle write-back strobe and data
//   pc_load, pc_o                   one-cycle next-PC strobe and value
//   err                             sticky memory-timeout flag
// ----------------------------------------------------------------------------
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_STEP = DEF_PC_STEP,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic              ife_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              reg_update,
    output logic [DATA_W-1:0] reg_o,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_o,
    output logic              err
);

    logic [1:0]        r_state;
    logic [5:0]        r_op;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_addr;
    logic              r_ife;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_reg_hold;
    logic [DATA_W-1:0] r_pc_hold;

    logic              w_accept;
    logic              w_mem_start;
    logic              w_mem_done;
    logic              w_timed_out;
    logic [DATA_W-1:0] w_rdata;
    logic              w_in_wb;
    logic              w_take_target;
    logic              w_upd;
    logic [DATA_W-1:0] w_next_pc;
    logic [DATA_W-1:0] w_wb_data;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_ready & in_valid;
    assign w_mem_start = w_accept & is_mem_op(op_i);

    dmem_if #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dmem_if (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_mem_start),
        .i_we        (op_i == OP_SW),
        .i_addr      (addr_i),
        .i_wdata     (alu_i),
        .i_ack       (dmem_ack),
        .i_rdata     (dmem_rdata),
        .o_req       (dmem_req),
        .o_we        (dmem_we),
        .o_addr      (dmem_addr),
        .o_wdata     (dmem_wdata),
        .o_done      (w_mem_done),
        .o_timed_out (w_timed_out),
        .o_rdata     (w_rdata),
        .o_err       (err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_alu   <= '0;
            r_addr  <= '0;
            r_ife   <= 1'b0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_i;
                        r_alu   <= alu_i;
                        r_addr  <= addr_i;
                        r_ife   <= ife_i;
                        r_pc    <= pc_i;
                        r_state <= is_mem_op(op_i) ? ST_MEM : ST_WB;
                    end
                end
                ST_MEM: begin
                    if (w_mem_done) begin
                        r_state <= ST_WB;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write-back / next-PC decode from the held instruction (Moore outputs)
    assign w_in_wb       = (r_state == ST_WB);
    assign w_take_target = (r_op == OP_JMP) || ((r_op == OP_BEQ) && r_ife);
    assign w_next_pc     = w_take_target ? r_addr : (r_pc + DATA_W'(PC_STEP));
    // w_timed_out is fresh for every LW because dmem_if clears it on start
    assign w_upd         = is_alu_op(r_op) || ((r_op == OP_LW) && !w_timed_out);
    assign w_wb_data     = (r_op == OP_LW) ? w_rdata : r_alu;

    assign reg_update = w_in_wb & w_upd;
    assign pc_load    = w_in_wb;
    assign reg_o      = reg_update ? w_wb_data : r_reg_hold;
    assign pc_o       = w_in_wb ? w_next_pc : r_pc_hold;

    // Last presented values, kept visible between WB cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_hold <= '0;
            r_pc_hold  <= '0;
        end else begin
            if (reg_update) r_reg_hold <= w_wb_data;
            if (w_in_wb)    r_pc_hold  <= w_next_pc;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam int TMO = 15;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op_i;
    logic [31:0] alu_i, addr_i, pc_i;
    logic        ife_i;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        reg_update, pc_load, err;
    logic [31:0] reg_o, pc_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_reg = 0;
    logic        m_err = 0;

    mem_wb_stage #(.DATA_W(32), .PC_STEP(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_i(op_i), .alu_i(alu_i), .addr_i(addr_i), .ife_i(ife_i), .pc_i(pc_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .reg_update(reg_update), .reg_o(reg_o), .pc_load(pc_load), .pc_o(pc_o),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] addr;
        logic        ife;
        logic [31:0] pc;
        int          lat;      // ack on this request cycle; 0 = never
        logic [31:0] rdata;
        logic        exp_upd;
        logic [31:0] exp_reg;
        logic [31:0] exp_pc;
        int          exp_req;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One instruction through the stage; inputs driven and outputs sampled
    // on falling edges.
    task automatic run_txn(input vec_t v);
        int req_cycles;
        logic exp_we;
        req_cycles = 0;
        exp_we = (v.op == OP_SW);
        @(negedge clk);
        chk({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op_i = v.op; alu_i = v.alu; addr_i = v.addr;
        ife_i = v.ife; pc_i = v.pc;
        @(negedge clk);
        in_valid = 1'b0; op_i = 6'($urandom); alu_i = $urandom; addr_i = $urandom;
        for (int c = 0; c < 40 && !pc_load; c++) begin
            if (dmem_req) begin
                req_cycles++;
                chk({v.name, ".dmem_we"}, 32'(dmem_we), 32'(exp_we));
                chk({v.name, ".dmem_addr"}, dmem_addr, v.addr);
                if (exp_we) chk({v.name, ".dmem_wdata"}, dmem_wdata, v.alu);
                dmem_ack = (v.lat != 0) && (req_cycles == v.lat);
                dmem_rdata = dmem_ack ? v.rdata : $urandom;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        chk({v.name, ".pc_load"}, 32'(pc_load), 32'd1);
        chk({v.name, ".req_cycles"}, 32'(req_cycles), 32'(v.exp_req));
        chk({v.name, ".reg_update"}, 32'(reg_update), 32'(v.exp_upd));
        if (v.exp_upd) chk({v.name, ".reg_o"}, reg_o, v.exp_reg);
        chk({v.name, ".pc_o"}, pc_o, v.exp_pc);
        chk({v.name, ".err"}, 32'(err), 32'(v.exp_err));
        if (v.exp_upd) last_reg = v.exp_reg;
        @(negedge clk);
        chk({v.name, ".pc_load_after"}, 32'(pc_load), 32'd0);
        chk({v.name, ".reg_o_hold"}, reg_o, last_reg);
        chk({v.name, ".pc_o_hold"}, pc_o, v.exp_pc);
        $display("txn %-12s op=%06b pc=%08h -> upd=%0d reg_o=%08h pc_o=%08h err=%0d",
                 v.name, v.op, v.pc, v.exp_upd, v.exp_reg, v.exp_pc, v.exp_err);
    endtask

    // Reference model straight from the stage rules
    function automatic vec_t model(input string nm, input logic [5:0] op,
                                   input logic [31:0] alu, input logic [31:0] addr,
                                   input logic ife, input logic [31:0] pc,
                                   input int lat, input logic [31:0] rdata);
        vec_t v;
        bit mem, tmo;
        v.name = nm; v.op = op; v.alu = alu; v.addr = addr; v.ife = ife;
        v.pc = pc; v.lat = lat; v.rdata = rdata;
        mem = (op == 6'b010001) || (op == 6'b010000);
        tmo = mem && (lat == 0 || lat > TMO);
        v.exp_req = !mem ? 0 : (tmo ? TMO : lat);
        v.exp_pc  = (op == 6'b100001 || (op == 6'b100000 && ife)) ? addr : pc + 32'd4;
        v.exp_upd = (op <= 6'd5) || (op == 6'b010001 && !tmo);
        v.exp_reg = (op == 6'b010001) ? rdata : alu;
        if (tmo) m_err = 1'b1;
        v.exp_err = m_err;
        return v;
    endfunction

    initial begin
        logic [5:0] op_pool[12];
        op_pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'b010000, 6'b010001,
                    6'b100000, 6'b100001, 6'b111111, 6'b001010};

        //            name       op          alu          addr         ife pc           lat rdata        upd reg          pc           req err
        vecs[0] = '{"add",      6'b000000, 32'd7,       32'h0,       0, 32'h10,       0,  32'h0,       1, 32'd7,       32'h14,       0,  0};
        vecs[1] = '{"lw",       6'b010001, 32'h9,       32'h40,      0, 32'h30,       3,  32'hDEAD,    1, 32'hDEAD,    32'h34,       3,  0};
        vecs[2] = '{"sw",       6'b010000, 32'h55,      32'h8,       0, 32'h50,       1,  32'h0,       0, 32'h0,       32'h54,       1,  0};
        vecs[3] = '{"beq_t",    6'b100000, 32'h1,       32'h100,     1, 32'h60,       0,  32'h0,       0, 32'h0,       32'h100,      0,  0};
        vecs[4] = '{"beq_nt",   6'b100000, 32'h1,       32'h300,     0, 32'h20,       0,  32'h0,       0, 32'h0,       32'h24,       0,  0};
        vecs[5] = '{"jmp",      6'b100001, 32'h2,       32'h200,     0, 32'h70,       0,  32'h0,       0, 32'h0,       32'h200,      0,  0};
        vecs[6] = '{"nop_wrap", 6'b111111, 32'h3,       32'h500,     1, 32'hFFFFFFFC, 0,  32'h0,       0, 32'h0,       32'h0,        0,  0};
        vecs[7] = '{"lw_ack15", 6'b010001, 32'h4,       32'h80,      0, 32'h90,       15, 32'hBEEF,    1, 32'hBEEF,    32'h94,       15, 0};
        vecs[8] = '{"sub",      6'b000001, 32'h1234,    32'h0,       0, 32'hA0,       0,  32'h0,       1, 32'h1234,    32'hA4,       0,  0};

        rst_n = 1'b0; in_valid = 1'b0; op_i = '0; alu_i = '0; addr_i = '0;
        ife_i = 1'b0; pc_i = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.reg_update", 32'(reg_update), 32'd0);
        chk("rst.pc_load", 32'(pc_load), 32'd0);
        chk("rst.reg_o", reg_o, 32'd0);
        chk("rst.pc_o", pc_o, 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Randomized instructions against the model
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = model("rand", op_pool[$urandom_range(11, 0)], $urandom, $urandom,
                      1'($urandom), $urandom, $urandom_range(6, 1), $urandom);
            run_txn(v);
        end

        // Ack while idle must be ignored
        @(negedge clk);
        dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ack.dmem_req", 32'(dmem_req), 32'd0);
        chk("idle_ack.in_ready", 32'(in_ready), 32'd1);
        chk("idle_ack.pc_load", 32'(pc_load), 32'd0);
        chk("idle_ack.err", 32'(err), 32'd0);
        dmem_ack = 1'b0;

        // Load that never gets an ack, then err must stay set
        run_txn(model("lw_timeout", 6'b010001, 32'h1, 32'hC0, 1'b0, 32'h200, 0, 32'h0));
        run_txn(model("add_err", 6'b000000, 32'h77, 32'h0, 1'b0, 32'h300, 0, 32'h0));

        // Reset in the middle of a memory access
        @(negedge clk);
        in_valid = 1'b1; op_i = 6'b010001; addr_i = 32'h44; pc_i = 32'h400;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstmem.req_before", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmem.dmem_req", 32'(dmem_req), 32'd0);
        chk("rstmem.in_ready", 32'(in_ready), 32'd1);
        chk("rstmem.reg_update", 32'(reg_update), 32'd0);
        chk("rstmem.pc_load", 32'(pc_load), 32'd0);
        chk("rstmem.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmem.no_wb", 32'(pc_load), 32'd0);
        end
        m_err = 1'b0;
        last_reg = 32'd0;
        run_txn(model("add_post", 6'b000000, 32'h5, 32'h0, 1'b0, 32'h500, 0, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
